mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port SP_SRAM (1-cycle read latency, active-low CSN/WEN) between the core's instruction-fetch port and its load/store port.
- Enables a unified instruction/data memory build of the RISC-V core.
- Grants one requester per cycle: data has priority, with a starvation guard for fetch.
- Returns read data one cycle after grant on the owning port and holds it until that port's next response.

Parameters:
AWIDTH, 12, SRAM word-address width; M_ADDR = byte_addr[AWIDTH+1:2]
DWIDTH, 32, data width
MAX_D_STREAK, 4, consecutive D grants allowed while I_REQ is pending before I is forced; range 1..15

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
I_REQ  in  1  fetch request (read only)
I_ADDR  in  32  fetch byte address
I_GNT  out  1  fetch accepted this cycle
I_RVALID  out  1  fetch data valid this cycle
I_RDATA  out  DWIDTH  fetch data
D_REQ  in  1  data request
D_WEN  in  1  0 = write, 1 = read (SRAM polarity)
D_BE  in  4  byte enables, passed through
D_ADDR  in  32  data byte address
D_WDATA  in  DWIDTH  write data
D_GNT  out  1  data request accepted this cycle
D_RVALID  out  1  load data valid this cycle (reads only)
D_RDATA  out  DWIDTH  load data
M_CSN  out  1  SRAM chip select, active-low
M_WEN  out  1  SRAM write enable, active-low
M_BE  out  4  SRAM byte enables
M_ADDR  out  AWIDTH  SRAM word address
M_DI  out  DWIDTH  SRAM write data
M_DOUT  in  DWIDTH  SRAM read data (valid the cycle after a read grant)

Behaviour:
- Reset (RST=1 at a rising edge, and while RST is high):
  - I_GNT=D_GNT=0, M_CSN=1, M_WEN=1, M_BE=0, M_ADDR=0, M_DI=0.
  - I_RVALID=D_RVALID=0, I_RDATA=D_RDATA=0.
  - Streak counter=0, response owner=NONE.
- Grant logic is combinational from the current request inputs and registered state:
  - Only D_REQ: D granted.
  - Only I_REQ: I granted.
  - Both, streak < MAX_D_STREAK: D granted.
  - Both, streak == MAX_D_STREAK: I granted.
  - Neither: no grant, M_CSN=1.
- On a D grant:
  - M_CSN=0, M_WEN=D_WEN, M_BE=D_BE, M_ADDR=D_ADDR[AWIDTH+1:2], M_DI=D_WDATA.
- On an I grant:
  - M_CSN=0, M_WEN=1, M_BE=0, M_ADDR=I_ADDR[AWIDTH+1:2], M_DI=0.
- A requester holds REQ and its address/data stable until it sees GNT. Deasserting before GNT is legal and simply withdraws the request.
- Streak counter:
  - +1 on a D grant while I_REQ=1, saturating at MAX_D_STREAK.
  - Cleared to 0 on any I grant, or in any cycle with I_REQ=0.
- Response owner register (NONE/I/D), loaded at each clock edge:
  - I on an I grant.
  - D on a D read grant (D_WEN=1).
  - NONE on a D write, no grant, or reset.
- Response cycle, latency exactly 1 cycle after grant:
  - owner=I: I_RVALID=1, I_RDATA=M_DOUT.
  - owner=D: D_RVALID=1, D_RDATA=M_DOUT.
  - The value is also captured into that port's hold register at the edge ending the response cycle.
  - Outside its response cycle, each RDATA output shows its hold register.
- Writes produce no RVALID. A write completes at its grant edge.
- Back-to-back grants are fully pipelined: a new grant can occur in the same cycle as the previous response (one access per cycle sustained).
- Address bits [1:0] and bits above AWIDTH+1 are ignored; no misalignment check. Address wrap is modulo 2^AWIDTH words.
- Reset during a response cycle: RVALID is forced 0, the hold register is cleared, and the owner becomes NONE.
- D_WEN, D_BE, D_WDATA are don't-care when D_REQ=0.

Decomposition:
- Shared package riscv_mem_pkg:
  - Owner encoding localparams OWN_NONE=2'd0, OWN_I=2'd1, OWN_D=2'd2.
  - Default AWIDTH/DWIDTH.
  - SRAM polarity constants CSN_ACT=1'b0, WEN_WRITE=1'b0.
- One sub-module, mem_rsp_hold: per-port response/hold register (inputs valid, data, RST; outputs RVALID, RDATA). Instantiated twice.
- Grant logic and streak counter stay in the top.

Test Plan:
- Reset then idle:
  - Stimulus: RST=1 for 2 cycles, I_REQ=1 with I_ADDR=0x8.
  - Response: no GNT, M_CSN=1, RDATA=0. First cycle after RST falls: I_GNT=1, M_ADDR=2. Next cycle: I_RVALID=1, I_RDATA equals SRAM word 2.
- Fetch stream:
  - Stimulus: I_REQ held, I_ADDR=0x0,0x4,0x8 on consecutive grants; SRAM preloaded 0x11,0x22,0x33.
  - Response: I_RVALID on 3 consecutive cycles with 0x11,0x22,0x33; I_RDATA then holds 0x33.
- Store then load:
  - Stimulus: D write, D_ADDR=0x3C00, D_WDATA=0xDEADBEEF, D_BE=4'hF; then D read of the same address.
  - Response: no D_RVALID after the write. D_RVALID one cycle after the read grant, D_RDATA=0xDEADBEEF, M_ADDR=0xF00 on both.
- Priority and starvation:
  - Stimulus: I_REQ and D_REQ both held high for 10 cycles, MAX_D_STREAK=4.
  - Response: grant sequence D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each I.
- Simultaneous response and grant:
  - Stimulus: D read grant at cycle n, I grant at n+1.
  - Response: at n+1, D_RVALID=1 and M_CSN=0 for I. At n+2, I_RVALID=1 and D_RDATA still holds the load value.
- Reset mid-response:
  - Stimulus: I grant at cycle n, RST=1 at n+1.
  - Response: I_RVALID=0, I_RDATA=0 at n+1; owner=NONE; no response after RST falls.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared constants for the unified instruction/data SRAM port:
// response-owner encoding, default widths and SRAM pin polarity.
package riscv_mem_pkg;

  localparam int unsigned DEF_AWIDTH = 12;
  localparam int unsigned DEF_DWIDTH = 32;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic CSN_ACT   = 1'b0;
  localparam logic CSN_IDLE  = 1'b1;
  localparam logic WEN_WRITE = 1'b0;
  localparam logic WEN_READ  = 1'b1;

endpackage : riscv_mem_pkg

// File: rtl/mem_rsp_hold.sv
// Per-port read response: passes SRAM data through in the response cycle
// and keeps the last returned word on the port until the next response.
module mem_rsp_hold
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic              rvalid_o,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] hold_q;
  logic [DWIDTH-1:0] hold_d;

  always_comb begin
    hold_d   = hold_q;
    rvalid_o = 1'b0;
    rdata_o  = hold_q;
    if (valid_i) begin
      hold_d = data_i;
    end
    // Reset wins over an in-flight response, both on the pins and in the hold.
    if (rst_i) begin
      rdata_o = '0;
    end else if (valid_i) begin
      rvalid_o = 1'b1;
      rdata_o  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

endmodule : mem_rsp_hold

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between the fetch and load/store ports:
// data wins by default, a streak counter forces a fetch grant to avoid starvation.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned AWIDTH       = DEF_AWIDTH,
  parameter int unsigned DWIDTH       = DEF_DWIDTH,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [31:0]       i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [DWIDTH-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_wen_i,
  input  logic [3:0]        d_be_i,
  input  logic [31:0]       d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic              m_csn_o,
  output logic              m_wen_o,
  output logic [3:0]        m_be_o,
  output logic [AWIDTH-1:0] m_addr_o,
  output logic [DWIDTH-1:0] m_di_o,
  input  logic [DWIDTH-1:0] m_dout_i
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic [1:0]    owner_q, owner_d;
  logic          streak_at_max;

  // Byte-offset and high address bits are don't-care on both ports.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr_i[31:AWIDTH+2], i_addr_i[1:0],
                              d_addr_i[31:AWIDTH+2], d_addr_i[1:0]};

  assign streak_at_max = (streak_q == STREAK_MAX);

  // Grants are decided in-cycle so the SRAM sees the access at the next edge.
  always_comb begin
    d_gnt_o = 1'b0;
    i_gnt_o = 1'b0;
    if (!rst_i) begin
      d_gnt_o = d_req_i && !(i_req_i && streak_at_max);
      i_gnt_o = i_req_i && !d_gnt_o;
    end
  end

  always_comb begin
    m_csn_o  = CSN_IDLE;
    m_wen_o  = WEN_READ;
    m_be_o   = 4'h0;
    m_addr_o = '0;
    m_di_o   = '0;
    if (d_gnt_o) begin
      m_csn_o  = CSN_ACT;
      m_wen_o  = d_wen_i;
      m_be_o   = d_be_i;
      m_addr_o = d_addr_i[AWIDTH+1:2];
      m_di_o   = d_wdata_i;
    end else if (i_gnt_o) begin
      m_csn_o  = CSN_ACT;
      m_addr_o = i_addr_i[AWIDTH+1:2];
    end
  end

  // Streak counts D wins only while a fetch is actually waiting.
  always_comb begin
    streak_d = streak_q;
    if (!i_req_i || i_gnt_o) begin
      streak_d = '0;
    end else if (d_gnt_o && !streak_at_max) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt_o) begin
      owner_d = OWN_I;
    end else if (d_gnt_o && (d_wen_i == WEN_READ)) begin
      owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streak_q <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      streak_q <= streak_d;
      owner_q  <= owner_d;
    end
  end

  mem_rsp_hold #(.DWIDTH(DWIDTH)) u_i_rsp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (owner_q == OWN_I),
    .data_i   (m_dout_i),
    .rvalid_o (i_rvalid_o),
    .rdata_o  (i_rdata_o)
  );

  mem_rsp_hold #(.DWIDTH(DWIDTH)) u_d_rsp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (owner_q == OWN_D),
    .data_i   (m_dout_i),
    .rvalid_o (d_rvalid_o),
    .rdata_o  (d_rdata_o)
  );

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle SRAM model.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_wen, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_csn, m_wen;
  logic [3:0]  m_be;
  logic [11:0] m_addr;
  logic [31:0] m_di, m_dout;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AWIDTH(12), .DWIDTH(32), .MAX_D_STREAK(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
    .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .d_req_i(d_req), .d_wen_i(d_wen), .d_be_i(d_be), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .m_csn_o(m_csn), .m_wen_o(m_wen), .m_be_o(m_be), .m_addr_o(m_addr),
    .m_di_o(m_di), .m_dout_i(m_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model; preload contents are (re)established while reset is held.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 32'h11;
      mem[1] <= 32'h22;
      mem[2] <= 32'h33;
    end else if (m_csn == 1'b0) begin
      if (m_wen == 1'b0) begin
        automatic logic [31:0] w = mem[m_addr];
        for (int b = 0; b < 4; b++)
          if (m_be[b]) w[8*b +: 8] = m_di[8*b +: 8];
        mem[m_addr] <= w;
      end else begin
        m_dout <= mem[m_addr];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0; d_req = 1'b0; d_wen = 1'b1; d_be = 4'h0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); i_req = 1'b1; i_addr = 32'h8;
    for (int k = 0; k < 2; k++) begin
      cyc(); #1;
      checks++;
      if ({i_gnt, d_gnt, m_csn} !== 3'b001) begin
        errors++; $display("FAIL reset_gnt_csn: got %b want 001", {i_gnt, d_gnt, m_csn});
      end
      checks++;
      if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !== 66'd0) begin
        errors++; $display("FAIL reset_rsp: got rv=%b%b i=%h d=%h want zeros", i_rvalid, d_rvalid, i_rdata, d_rdata);
      end
    end
    cyc(); rst = 1'b0; #1;
    checks++;
    if (i_gnt !== 1'b1 || m_addr !== 12'd2 || m_csn !== 1'b0 || m_wen !== 1'b1) begin
      errors++; $display("FAIL reset_first_grant: got gnt=%b addr=%h csn=%b wen=%b want 1 002 0 1", i_gnt, m_addr, m_csn, m_wen);
    end
    cyc(); i_req = 1'b0; #1;
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'h33) begin
      errors++; $display("FAIL reset_first_rsp: got rv=%b data=%h want 1 00000033", i_rvalid, i_rdata);
    end
  endtask

  task automatic test_fetch_stream();
    logic [31:0] exp_data [3] = '{32'h11, 32'h22, 32'h33};
    for (int k = 0; k < 4; k++) begin
      cyc();
      i_req = (k < 3); i_addr = 32'(4 * k); #1;
      if (k > 0) begin
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== exp_data[k-1]) begin
          errors++; $display("FAIL fetch_rsp%0d: got rv=%b data=%h want 1 %h", k, i_rvalid, i_rdata, exp_data[k-1]);
        end
      end
      if (k < 3) begin
        checks++;
        if (i_gnt !== 1'b1 || m_addr !== 12'(k)) begin
          errors++; $display("FAIL fetch_gnt%0d: got gnt=%b addr=%h want 1 %h", k, i_gnt, m_addr, 12'(k));
        end
      end
    end
    cyc(); #1;
    checks++;
    if (i_rvalid !== 1'b0 || i_rdata !== 32'h33) begin
      errors++; $display("FAIL fetch_hold: got rv=%b data=%h want 0 00000033", i_rvalid, i_rdata);
    end
  endtask

  task automatic test_store_load();
    cyc(); idle();
    d_req = 1'b1; d_wen = 1'b0; d_be = 4'hF; d_addr = 32'h3C00; d_wdata = 32'hDEADBEEF; #1;
    checks++;
    if (d_gnt !== 1'b1 || m_addr !== 12'hF00 || m_wen !== 1'b0 || m_be !== 4'hF || m_di !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_drive: got gnt=%b addr=%h wen=%b be=%h di=%h", d_gnt, m_addr, m_wen, m_be, m_di);
    end
    cyc(); d_wen = 1'b1; d_wdata = '0; #1;
    checks++;
    if (d_rvalid !== 1'b0 || d_gnt !== 1'b1 || m_addr !== 12'hF00 || m_wen !== 1'b1) begin
      errors++; $display("FAIL load_drive: got rv=%b gnt=%b addr=%h wen=%b want 0 1 f00 1", d_rvalid, d_gnt, m_addr, m_wen);
    end
    cyc(); idle(); #1;
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_rsp: got rv=%b data=%h want 1 deadbeef", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_back_to_back();
    cyc(); idle(); d_req = 1'b1; d_addr = 32'h3C00; #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL b2b_d_gnt: got %b want 1", d_gnt);
    end
    cyc(); idle(); i_req = 1'b1; i_addr = 32'h4; #1;
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF || i_gnt !== 1'b1 || m_csn !== 1'b0 || m_addr !== 12'd1 || m_be !== 4'h0) begin
      errors++; $display("FAIL b2b_overlap: got drv=%b dd=%h ig=%b csn=%b addr=%h be=%h", d_rvalid, d_rdata, i_gnt, m_csn, m_addr, m_be);
    end
    cyc(); idle(); #1;
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'h22 || d_rvalid !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL b2b_tail: got irv=%b id=%h drv=%b dd=%h", i_rvalid, i_rdata, d_rvalid, d_rdata);
    end
  endtask

  task automatic test_byte_enable_wrap();
    cyc(); idle();
    d_req = 1'b1; d_wen = 1'b0; d_be = 4'b0011; d_addr = 32'h3C00; d_wdata = 32'h12345678; #1;
    checks++;
    if (m_be !== 4'b0011) begin
      errors++; $display("FAIL be_pass: got %b want 0011", m_be);
    end
    cyc(); d_wen = 1'b1; d_be = 4'hF;
    cyc(); d_wen = 1'b0; d_addr = 32'hFFFF_C004; d_wdata = 32'hCAFEF00D; #1;
    checks++;
    if (m_addr !== 12'd1 || d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD5678) begin
      errors++; $display("FAIL wrap_and_merge: got addr=%h rv=%b data=%h want 001 1 dead5678", m_addr, d_rvalid, d_rdata);
    end
    cyc(); idle(); #1;
    checks++;
    if (d_rvalid !== 1'b0 || d_rdata !== 32'hDEAD5678) begin
      errors++; $display("FAIL write_no_rvalid: got rv=%b data=%h want 0 dead5678", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_priority();
    bit exp_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    cyc(); idle();
    for (int k = 0; k < 10; k++) begin
      i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h8; #1;
      checks++;
      if ({i_gnt, d_gnt} !== {exp_i[k], ~exp_i[k]}) begin
        errors++; $display("FAIL prio_cycle%0d: got i=%b d=%b want i=%b", k, i_gnt, d_gnt, exp_i[k]);
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_streak_clear();
    bit ireq [9]  = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    bit exp_i [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    cyc(); idle();
    for (int k = 0; k < 9; k++) begin
      i_req = ireq[k]; i_addr = 32'h0; d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h8; #1;
      checks++;
      if ({i_gnt, d_gnt} !== {exp_i[k], ~exp_i[k]}) begin
        errors++; $display("FAIL streak_cycle%0d: got i=%b d=%b want i=%b", k, i_gnt, d_gnt, exp_i[k]);
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    cyc(); idle(); i_req = 1'b1; i_addr = 32'h4; #1;
    checks++;
    if (i_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_gnt: got %b want 1", i_gnt);
    end
    cyc(); idle(); rst = 1'b1; #1;
    checks++;
    if (i_rvalid !== 1'b0 || i_rdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_rsp: got rv=%b data=%h want 0 00000000", i_rvalid, i_rdata);
    end
    cyc(); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++;
      if (i_rvalid !== 1'b0 || i_rdata !== 32'h0 || d_rvalid !== 1'b0) begin
        errors++; $display("FAIL rstmid_after%0d: got irv=%b id=%h drv=%b want 0 0 0", k, i_rvalid, i_rdata, d_rvalid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_store_load();
    test_back_to_back();
    test_byte_enable_wrap();
    test_priority();
    test_streak_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter
